b2bd_sched: RTL and testbench

- Round-robin scheduler that shares one sequential shift-add-3 binary-to-BCD engine among N_REQ requesters.
- Arbitrates requests, captures the winner's operand and runs W_IN shift iterations.
- Presents the packed-BCD result with a valid/ready handshake plus the requester ID.
- Sits between several producers of 8-bit binary values and one BCD consumer (display/formatter).

---
 rtl/b2bd_sched_if.sv | 27 ++
 rtl/b2bd_sched.sv | 119 +++++++++++
 tb/tb_b2bd_sched.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/b2bd_sched_if.sv
// Bundle between the requesters/consumer and the b2bd_sched engine.
//
// Handshakes:
//   req/gnt     : requester holds req (level) and its bc slice stable until it sees
//                 its one-cycle gnt pulse; the operand is sampled on that grant edge.
//   bdc_valid/  : bdc/bdc_id are held stable while bdc_valid=1 and bdc_ready=0;
//   bdc_ready     the result is consumed on the rising edge where both are 1.
interface b2bd_sched_if #(
   parameter int N_REQ = 4,
   parameter int W_IN  = 8,
   parameter int W_OUT = 12,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]      req;
   logic [N_REQ*W_IN-1:0] bc;
   logic [N_REQ-1:0]      gnt;
   logic [W_OUT-1:0]      bdc;
   logic                  bdc_valid;
   logic [ID_W-1:0]       bdc_id;
   logic                  bdc_ready;
   logic                  busy;

   modport master (output req, bc, bdc_ready,
                   input  gnt, bdc, bdc_valid, bdc_id, busy);
   modport slave  (input  req, bc, bdc_ready,
                   output gnt, bdc, bdc_valid, bdc_id, busy);
endinterface

// File: rtl/b2bd_sched.sv
// Round-robin scheduler sharing one sequential shift-add-3 binary-to-BCD engine
// among N_REQ requesters. One conversion takes W_IN shift cycles; the result is
// offered with valid/ready together with the owning requester index.
module b2bd_sched #(
   parameter int N_REQ = 4,
   parameter int W_IN  = 8,
   parameter int W_OUT = 12,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic          clk,
   input  logic          rst_n,
   b2bd_sched_if.slave   bus,
   output logic [1:0]    o_dbg_state
);
   localparam int CNT_W = (W_IN > 1) ? $clog2(W_IN) : 1;
   localparam int N_DIG = W_OUT / 4;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t             r_state;
   logic [ID_W-1:0]    r_ptr;
   logic [ID_W-1:0]    r_w;
   logic [CNT_W-1:0]   r_cnt;
   logic [W_OUT-1:0]   r_acc;
   logic [W_IN-1:0]    r_bin;
   logic [N_REQ-1:0]   r_gnt;
   logic [W_OUT-1:0]   r_bdc;
   logic               r_valid;
   logic [ID_W-1:0]    r_id;

   logic               w_found;
   logic [ID_W-1:0]    w_win;
   logic [W_OUT-1:0]   w_adj;
   logic [W_OUT-1:0]   w_acc_nxt;
   logic [W_IN-1:0]    w_bin_nxt;

   // Winner: first set req bit at or above the pointer, wrapping. Scanning k
   // downward lets the smallest distance from the pointer overwrite last.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(r_ptr) + k) % N_REQ;
         if (bus.req[idx]) begin
            w_found = 1'b1;
            w_win   = ID_W'(idx);
         end
      end
   end

   // One shift-add-3 iteration: correct every digit >=5, then shift {acc,bin} left.
   always_comb begin
      w_adj = r_acc;
      for (int d = 0; d < N_DIG; d++) begin
         if (r_acc[d*4 +: 4] >= 4'd5)
            w_adj[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
      end
      w_acc_nxt = {w_adj[W_OUT-2:0], r_bin[W_IN-1]};
      w_bin_nxt = {r_bin[W_IN-2:0], 1'b0};
   end

   // Scheduler FSM with registered grant and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_w     <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_bin   <= '0;
         r_gnt   <= '0;
         r_bdc   <= '0;
         r_valid <= 1'b0;
         r_id    <= '0;
      end else begin
         r_gnt <= '0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt   <= N_REQ'(1) << w_win;
                  r_w     <= w_win;
                  r_acc   <= '0;
                  r_bin   <= bus.bc[w_win*W_IN +: W_IN];
                  r_cnt   <= '0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_acc <= w_acc_nxt;
               r_bin <= w_bin_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(W_IN - 1)) begin
                  r_bdc   <= w_acc_nxt;
                  r_id    <= r_w;
                  r_valid <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               // Pointer moves only on acceptance, so a waiting channel is not skipped.
               if (bus.bdc_ready) begin
                  r_valid <= 1'b0;
                  r_ptr   <= (int'(r_w) == N_REQ - 1) ? '0 : r_w + 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.bdc       = r_bdc;
   assign bus.bdc_valid = r_valid;
   assign bus.bdc_id    = r_id;
   assign bus.busy      = (r_state != IDLE);
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_b2bd_sched.sv
// Directed bench for b2bd_sched: single request, ordered grants, fairness,
// backpressure, mid-conversion reset and a full 0..255 sweep on channel 2.
module tb_b2bd_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [11:0] exp_q[$];

  b2bd_sched_if #(.N_REQ(4), .W_IN(8), .W_OUT(12)) ifc ();

  b2bd_sched #(.N_REQ(4), .W_IN(8), .W_OUT(12)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc.slave),
    .o_dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ifc.req = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_bc(input int ch, input logic [7:0] v);
    ifc.bc[ch*8 +: 8] = v;
  endtask

  // Waits (bounded) for a grant pulse; returns it and the cycle it was seen in.
  task automatic wait_gnt(output logic [3:0] g, output int t);
    g = '0;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.gnt != '0) begin
        g = ifc.gnt;
        t = cyc;
        return;
      end
    end
    check("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Waits (bounded) for bdc_valid; reports cycles waited and whether busy stayed high.
  task automatic wait_valid(output int lat, output logic busy_all);
    lat = 0;
    busy_all = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!ifc.busy) busy_all = 1'b0;
      if (ifc.bdc_valid) begin
        lat = i;
        return;
      end
    end
    check("valid_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [11:0] bcd_ref(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  initial begin
    logic [3:0] g;
    int t, tprev, lat;
    logic busy_all, ok, seen;

    ifc.req = '0;
    ifc.bc = '0;
    ifc.bdc_ready = 1'b1;

    // reset state
    #1;
    check("rst_gnt", 32'(ifc.gnt), 32'd0);
    check("rst_bdc", 32'(ifc.bdc), 32'd0);
    check("rst_valid", 32'(ifc.bdc_valid), 32'd0);
    check("rst_id", 32'(ifc.bdc_id), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single request
    set_bc(0, 8'd255);
    ifc.req = 4'b0001;
    wait_gnt(g, t);
    check("t1_gnt", 32'(g), 32'h1);
    ifc.req = '0;
    @(negedge clk);
    check("t1_gnt_pulse", 32'(ifc.gnt), 32'h0);
    // already one cycle past the grant cycle
    wait_valid(lat, busy_all);
    check("t1_latency", 32'(lat + 1), 32'd8);
    check("t1_busy", 32'(busy_all), 32'd1);
    check("t1_bdc", 32'(ifc.bdc), 32'h255);
    check("t1_id", 32'(ifc.bdc_id), 32'd0);

    // simultaneous requests, in-order grants
    do_reset();
    set_bc(0, 8'd0); set_bc(1, 8'd9); set_bc(2, 8'd100); set_bc(3, 8'd173);
    exp_q = {12'h000, 12'h009, 12'h100, 12'h173};
    ifc.req = 4'b1111;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, t);
      check($sformatf("t2_gnt%0d", i), 32'(g), 32'(4'b0001 << i));
      ifc.req = ifc.req & ~g;
      if (i > 0) check($sformatf("t2_gap%0d", i), 32'(t - tprev), 32'd10);
      tprev = t;
      wait_valid(lat, busy_all);
      check($sformatf("t2_bdc%0d", i), 32'(ifc.bdc), 32'(exp_q.pop_front()));
      check($sformatf("t2_id%0d", i), 32'(ifc.bdc_id), i);
    end

    // fairness: ch1 and ch3 held continuously
    do_reset();
    set_bc(1, 8'd42); set_bc(3, 8'd199);
    ifc.req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(g, t);
      check($sformatf("t3_gnt%0d", i), 32'(g), (i % 2 == 0) ? 32'h2 : 32'h8);
      wait_valid(lat, busy_all);
      if (i == 3) ifc.req = '0;
      check($sformatf("t3_bdc%0d", i), 32'(ifc.bdc), (i % 2 == 0) ? 32'h042 : 32'h199);
      check($sformatf("t3_id%0d", i), 32'(ifc.bdc_id), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // backpressure
    do_reset();
    ifc.bdc_ready = 1'b0;
    set_bc(0, 8'd77); set_bc(2, 8'd50);
    ifc.req = 4'b0001;
    wait_gnt(g, t);
    ifc.req = '0;
    wait_valid(lat, busy_all);
    ifc.req = 4'b0100;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ifc.bdc_valid !== 1'b1 || ifc.bdc !== 12'h077 || ifc.bdc_id !== 2'd0 ||
          ifc.gnt !== 4'b0 || ifc.busy !== 1'b1) ok = 1'b0;
    end
    check("t4_hold", 32'(ok), 32'd1);
    ifc.bdc_ready = 1'b1;
    @(negedge clk);
    check("t4_acc_valid", 32'(ifc.bdc_valid), 32'd0);
    check("t4_acc_gnt", 32'(ifc.gnt), 32'h0);
    check("t4_acc_busy", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    check("t4_gnt2", 32'(ifc.gnt), 32'h4);
    ifc.req = '0;
    wait_valid(lat, busy_all);
    check("t4_bdc", 32'(ifc.bdc), 32'h050);
    check("t4_id", 32'(ifc.bdc_id), 32'd2);

    // mid-conversion reset
    do_reset();
    set_bc(3, 8'd200);
    ifc.req = 4'b1000;
    wait_gnt(g, t);
    check("t5_gnt", 32'(g), 32'h8);
    ifc.req = '0;
    repeat (4) @(negedge clk);
    check("t5_state_shift", 32'(dbg_state), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(ifc.busy), 32'd0);
    check("t5_valid", 32'(ifc.bdc_valid), 32'd0);
    check("t5_bdc", 32'(ifc.bdc), 32'd0);
    check("t5_gnt0", 32'(ifc.gnt), 32'd0);
    check("t5_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ifc.bdc_valid) seen = 1'b1;
    end
    check("t5_no_result", 32'(seen), 32'd0);
    set_bc(0, 8'd11); set_bc(3, 8'd33);
    ifc.req = 4'b1001;
    wait_gnt(g, t);
    check("t5_first_ch0", 32'(g), 32'h1);
    ifc.req = 4'b1000;
    wait_valid(lat, busy_all);
    check("t5_bdc_ch0", 32'(ifc.bdc), 32'h011);
    wait_gnt(g, t);
    check("t5_then_ch3", 32'(g), 32'h8);
    ifc.req = '0;
    wait_valid(lat, busy_all);
    check("t5_bdc_ch3", 32'(ifc.bdc), 32'h033);

    // exhaustive sweep on ch2
    do_reset();
    for (int v = 0; v < 256; v++) begin
      set_bc(2, 8'(v));
      exp_q.push_back(bcd_ref(v));
      ifc.req = 4'b0100;
      wait_gnt(g, t);
      ifc.req = '0;
      wait_valid(lat, busy_all);
      check($sformatf("t6_bdc_%0d", v), 32'(ifc.bdc), 32'(exp_q.pop_front()));
      check($sformatf("t6_id_%0d", v), 32'(ifc.bdc_id), 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
